branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Parametrised successor to the decode-stage branch comparator. It evaluates six MIPS branch conditions on WIDTH-bit operands and holds a PC-indexed 2-bit saturating branch history table (BHT) that supplies a prediction. Each branch resolves into a single output register stage that reports taken and mispredict. It sits in D→E, between operand forwarding muxes and the NPC/flush logic.

Parameters:
WIDTH, 32, operand width in bits (≥2)
BHT_DEPTH, 16, BHT entries; power of two, ≥2
IDX_LSB, 2, lowest PC bit used for the BHT index

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
valid_i  in  1  a branch instruction is present in D this cycle
stall_i  in  1  pipeline stall; hold all state
flush_i  in  1  kill the D-stage instruction
op_i  in  3  condition: 0 NONE, 1 BEQ, 2 BNE, 3 BLEZ, 4 BGTZ, 5 BLTZ, 6 BGEZ, 7 reserved (treated as NONE)
a_i  in  WIDTH  rs operand (forwarded)
b_i  in  WIDTH  rt operand (forwarded; ignored by zero-compare ops)
pc_i  in  32  PC of the D-stage instruction
pred_taken_o  out  1  combinational prediction: MSB of BHT[pc_i index]
taken_o  out  1  registered: resolved condition
resolved_o  out  1  registered: taken_o/mispredict_o valid this cycle
mispredict_o  out  1  registered: resolved condition ≠ prediction used
stat_branches_o  out  32  resolved-branch count (see Optional Feature)
stat_mispred_o  out  32  mispredict count (see Optional Feature)

Behaviour:
- idx = pc_i[IDX_LSB +: log2(BHT_DEPTH)]. pred_taken_o = BHT[idx][1], read combinationally before any same-edge update.
- Conditions: BEQ a==b; BNE a!=b. BLEZ, BGTZ, BLTZ and BGEZ compare a_i as signed against zero: sign = a_i[WIDTH-1], zero = (a_i==0). NONE/reserved gives cond=0.
- fire = valid_i & ~stall_i & ~flush_i & (op_i ∈ 1..6).
- On a clk rising edge with reset high:
  - flush_i=1 (has priority over stall_i): resolved_o←0, mispredict_o←0, taken_o←0, no BHT update.
  - Otherwise stall_i=1: all registers and the BHT hold.
  - Otherwise fire: taken_o←cond, resolved_o←1, mispredict_o←(cond≠pred_taken_o). BHT[idx] saturating-increments if cond, else saturating-decrements. 11 stays 11; 00 stays 00.
  - Otherwise (no fire): resolved_o←0, mispredict_o←0, taken_o←0.
- Latency: exactly 1 cycle from fire to resolved_o.
- Reset (async assert, reset=0): taken_o, resolved_o, mispredict_o, stat_* ←0; every BHT entry ←2'b01 (weakly not-taken). Asserting reset mid-operation discards the in-flight result. Deassertion is assumed synchronous to clk upstream.
- Back-to-back fires to the same idx: the second one sees the first one's updated counter.
- Index aliasing is permitted; no tags.

Optional Feature:
BRANCH_STATS_EN
- Defined: stat_branches_o increments on every fire, and stat_mispred_o increments on every fire that mispredicts. Both saturate at 32'hFFFFFFFF, hold under stall, are unaffected by flush, and reset to 0.
- Undefined: both ports remain present and are tied to 0; no counter flops are synthesised.

Decomposition:
- Package branch_pkg: op_i encodings (BR_NONE…BR_BGEZ), BHT_RESET_VAL = 2'b01, counter width 2, macro guard for BRANCH_STATS_EN.
- One sub-module, bht_table: holds BHT_DEPTH 2-bit counters with async active-low reset. It has a combinational read port (rd_idx→rd_ctr) and a synchronous saturating update port (wr_en, wr_idx, wr_taken).
- Top level handles comparison, the result register and the stats.

Test Plan:
1. Reset, then BEQ a=b=32'h5, pc=0x3000 → pred_taken_o=0; next cycle taken_o=1, resolved_o=1, mispredict_o=1; BHT[0] becomes 10.
2. Repeat the same BEQ at the same pc 3× → mispredict_o=0 on the 2nd and 3rd; counter saturates at 11; a 4th with a=1, b=2 → taken_o=0, mispredict_o=1, counter 10.
3. Sign checks with a_i=32'h80000000: BLTZ → taken 1; BGEZ → 0; BLEZ → 1; BGTZ → 0. With a_i=0: BLEZ 1, BGEZ 1, BGTZ 0, BLTZ 0.
4. stall_i=1 with a valid BNE for 3 cycles → outputs hold their previous values and the BHT is unchanged; release → resolves one cycle later.
5. flush_i=1 and stall_i=1 together with a valid BEQ → resolved_o=0 next cycle, BHT unchanged. reset pulsed low mid-stream → outputs 0 immediately, all entries 01.
6. With BRANCH_STATS_EN, run 10 fires including 4 mispredicts → stat_branches_o=10, stat_mispred_o=4. Without it → both read 0.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: condition encodings, BHT
// counter constants and the saturating counter step.
// Optional feature macro: BRANCH_STATS_EN (resolved/mispredict counters).
package branch_pkg;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BEQ  = 3'd1,
        BR_BNE  = 3'd2,
        BR_BLEZ = 3'd3,
        BR_BGTZ = 3'd4,
        BR_BLTZ = 3'd5,
        BR_BGEZ = 3'd6,
        BR_RSVD = 3'd7
    } br_op_e;

    localparam int          CTR_W         = 2;
    localparam logic [CTR_W-1:0] BHT_RESET_VAL = 2'b01;

`ifdef BRANCH_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    // Saturating 2-bit step: up on taken, down on not-taken, clamp at 11/00.
    function automatic logic [CTR_W-1:0] ctr_next(input logic [CTR_W-1:0] c,
                                                   input logic taken);
        logic [CTR_W-1:0] n;
        n = c;
        if (taken) begin
            if (c != 2'b11) n = c + 2'd1;
        end else begin
            if (c != 2'b00) n = c - 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table: DEPTH 2-bit saturating counters, combinational read,
// synchronous saturating update, async active-low reset to weakly not-taken.
module bht_table
    import branch_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CTR_W-1:0] rd_ctr,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [DEPTH-1:0][CTR_W-1:0] ctr_q;

    // Read sees the pre-update value so the prediction matches what resolves.
    assign rd_ctr = ctr_q[rd_idx];

    // Counter storage with saturating update on a resolving branch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= BHT_RESET_VAL;
        end else if (wr_en) begin
            ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// D->E branch resolver: evaluates the six MIPS branch conditions, predicts
// from a PC-indexed BHT and registers taken/resolved/mispredict one cycle on.
// Optional feature macro: BRANCH_STATS_EN (stat_* counters; tied 0 otherwise).
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 16,
    parameter int IDX_LSB   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [31:0]      pc_i,
    output logic             pred_taken_o,
    output logic             taken_o,
    output logic             resolved_o,
    output logic             mispredict_o,
    output logic [31:0]      stat_branches_o,
    output logic [31:0]      stat_mispred_o
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [IDX_W-1:0] idx;
    logic [CTR_W-1:0] ctr;
    logic             cond;
    logic             op_ok;
    logic             fire;
    logic             a_zero;
    logic             a_neg;
    logic             taken_q, resolved_q, mispred_q;
    logic             unused_pc;

    assign idx       = pc_i[IDX_LSB +: IDX_W];
    assign unused_pc = ^pc_i;
    assign a_zero    = (a_i == '0);
    assign a_neg     = a_i[WIDTH-1];

    bht_table #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx),
        .rd_ctr   (ctr),
        .wr_en    (fire),
        .wr_idx   (idx),
        .wr_taken (cond)
    );

    assign pred_taken_o = ctr[CTR_W-1];

    // Branch condition decode; NONE and the reserved code never take.
    always_comb begin
        cond  = 1'b0;
        op_ok = 1'b1;
        case (op_i)
            BR_BEQ:  cond = (a_i == b_i);
            BR_BNE:  cond = (a_i != b_i);
            BR_BLEZ: cond = a_neg | a_zero;
            BR_BGTZ: cond = ~a_neg & ~a_zero;
            BR_BLTZ: cond = a_neg;
            BR_BGEZ: cond = ~a_neg;
            default: op_ok = 1'b0;
        endcase
    end

    assign fire = valid_i & ~stall_i & ~flush_i & op_ok;

    // Result register: flush clears, stall holds, otherwise capture this cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            taken_q    <= 1'b0;
            resolved_q <= 1'b0;
            mispred_q  <= 1'b0;
        end else if (flush_i) begin
            taken_q    <= 1'b0;
            resolved_q <= 1'b0;
            mispred_q  <= 1'b0;
        end else if (!stall_i) begin
            taken_q    <= fire & cond;
            resolved_q <= fire;
            mispred_q  <= fire & (cond ^ pred_taken_o);
        end
    end

    assign taken_o      = taken_q;
    assign resolved_o   = resolved_q;
    assign mispredict_o = mispred_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    // Saturating event counters; fire already excludes stall and flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_br_q <= '0;
            stat_mp_q <= '0;
        end else if (fire) begin
            if (stat_br_q != 32'hFFFF_FFFF) stat_br_q <= stat_br_q + 32'd1;
            if ((cond ^ pred_taken_o) && (stat_mp_q != 32'hFFFF_FFFF))
                stat_mp_q <= stat_mp_q + 32'd1;
        end
    end

    assign stat_branches_o = stat_br_q;
    assign stat_mispred_o  = stat_mp_q;
`else
    assign stat_branches_o = '0;
    assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; BHT state is inferred through
// pred_taken_o and mispredict_o across hand-worked sequences.
module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic        valid_i, stall_i, flush_i;
    logic [2:0]  op_i;
    logic [31:0] a_i, b_i, pc_i;
    logic        pred_taken_o, taken_o, resolved_o, mispredict_o;
    logic [31:0] stat_branches_o, stat_mispred_o;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    branch_resolve_unit #(.WIDTH(32), .BHT_DEPTH(16), .IDX_LSB(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .valid_i         (valid_i),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .op_i            (op_i),
        .a_i             (a_i),
        .b_i             (b_i),
        .pc_i            (pc_i),
        .pred_taken_o    (pred_taken_o),
        .taken_o         (taken_o),
        .resolved_o      (resolved_o),
        .mispredict_o    (mispredict_o),
        .stat_branches_o (stat_branches_o),
        .stat_mispred_o  (stat_mispred_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        exp_taken;
        logic        exp_res;
    } vec_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic f, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        valid_i = v; stall_i = s; flush_i = f; op_i = op; a_i = a; b_i = b; pc_i = pc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic t, input logic r, input logic m);
        chk({tag, ".taken"}, {31'd0, taken_o}, {31'd0, t});
        chk({tag, ".resolved"}, {31'd0, resolved_o}, {31'd0, r});
        chk({tag, ".mispred"}, {31'd0, mispredict_o}, {31'd0, m});
    endtask

    vec_t sv[12];
    logic st_t[10];

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 3'd0, 0, 0, 32'h3000);
        #12;
        // reset state
        chk_out("reset", 0, 0, 0);
        chk("reset.pred", {31'd0, pred_taken_o}, 0);
        chk("reset.stat_br", stat_branches_o, 0);
        chk("reset.stat_mp", stat_mispred_o, 0);
        reset = 1'b1;
        tick();

        // 1: first BEQ taken at idx 0, weakly not-taken prediction
        drive(1, 0, 0, 3'd1, 32'h5, 32'h5, 32'h3000);
        #1 chk("t1.pred0", {31'd0, pred_taken_o}, 0);
        tick();
        chk_out("t1", 1, 1, 1);
        chk("t1.pred10", {31'd0, pred_taken_o}, 1);

        // 2: three more taken (10->11, saturate), then two not-taken -> 01
        tick(); chk_out("t2.r1", 1, 1, 0);
        tick(); chk_out("t2.r2", 1, 1, 0);
        tick(); chk_out("t2.r3", 1, 1, 0);
        drive(1, 0, 0, 3'd1, 32'h1, 32'h2, 32'h3000);
        tick(); chk_out("t2.nt1", 0, 1, 1);
        chk("t2.pred10", {31'd0, pred_taken_o}, 1);
        tick(); chk_out("t2.nt2", 0, 1, 1);
        chk("t2.pred01", {31'd0, pred_taken_o}, 0);
        drive(0, 0, 0, 3'd1, 32'h1, 32'h2, 32'h3000);
        tick(); chk_out("t2.idle", 0, 0, 0);

        // 3: zero-compare ops, plus non-firing op codes
        sv = '{
            '{3'd5, 32'h8000_0000, 32'h0, 1'b1, 1'b1},
            '{3'd6, 32'h8000_0000, 32'h0, 1'b0, 1'b1},
            '{3'd3, 32'h8000_0000, 32'h0, 1'b1, 1'b1},
            '{3'd4, 32'h8000_0000, 32'h0, 1'b0, 1'b1},
            '{3'd3, 32'h0,         32'h7, 1'b1, 1'b1},
            '{3'd6, 32'h0,         32'h7, 1'b1, 1'b1},
            '{3'd4, 32'h0,         32'h7, 1'b0, 1'b1},
            '{3'd5, 32'h0,         32'h7, 1'b0, 1'b1},
            '{3'd4, 32'h1,         32'h0, 1'b1, 1'b1},
            '{3'd2, 32'h1,         32'h2, 1'b1, 1'b1},
            '{3'd7, 32'h5,         32'h5, 1'b0, 1'b0},
            '{3'd0, 32'h5,         32'h5, 1'b0, 1'b0}
        };
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 0, sv[i].op, sv[i].a, sv[i].b, 32'h3004);
            tick();
            chk($sformatf("t3.v%0d.taken", i), {31'd0, taken_o}, {31'd0, sv[i].exp_taken});
            chk($sformatf("t3.v%0d.res", i), {31'd0, resolved_o}, {31'd0, sv[i].exp_res});
        end

        // 4: stall holds outputs and BHT (idx 2: 01 -> 00 by setup)
        drive(1, 0, 0, 3'd2, 32'h1, 32'h1, 32'h3008);
        tick(); chk_out("t4.setup", 0, 1, 0);
        drive(1, 1, 0, 3'd2, 32'h1, 32'h2, 32'h3008);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("t4.stall%0d", i), 0, 1, 0);
        end
        chk("t4.pred_hold", {31'd0, pred_taken_o}, 0);
        stall_i = 1'b0;
        tick(); chk_out("t4.release", 1, 1, 1);
        chk("t4.pred01", {31'd0, pred_taken_o}, 0);

        // 5: flush beats stall, no BHT update; then a real fire still mispredicts
        drive(1, 1, 1, 3'd1, 32'h9, 32'h9, 32'h3008);
        tick(); chk_out("t5.flush", 0, 0, 0);
        chk("t5.pred", {31'd0, pred_taken_o}, 0);
        drive(1, 0, 0, 3'd1, 32'h9, 32'h9, 32'h3008);
        tick(); chk_out("t5.fire", 1, 1, 1);
        chk("t5.pred10", {31'd0, pred_taken_o}, 1);

        // reset pulsed mid-cycle: outputs clear at once, entries back to 01
        #2 reset = 1'b0;
        #1 chk_out("t5.rst", 0, 0, 0);
        chk("t5.rst_pred2", {31'd0, pred_taken_o}, 0);
        pc_i = 32'h3000;
        #1 chk("t5.rst_pred0", {31'd0, pred_taken_o}, 0);
        drive(0, 0, 0, 3'd0, 0, 0, 32'h300C);
        tick();
        reset = 1'b1;
        tick();

        // 6: 10 fires on idx 3 with 4 mispredicts
        st_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 3'd1, 32'h4, st_t[i] ? 32'h4 : 32'h3, 32'h300C);
            tick();
        end
        drive(1, 1, 0, 3'd1, 32'h4, 32'h4, 32'h300C);
        tick();
        drive(1, 0, 1, 3'd1, 32'h4, 32'h4, 32'h300C);
        tick();
        drive(0, 0, 0, 3'd0, 0, 0, 32'h300C);
        tick();
`ifdef BRANCH_STATS_EN
        chk("t6.stat_br", stat_branches_o, 32'd10);
        chk("t6.stat_mp", stat_mispred_o, 32'd4);
`else
        chk("t6.stat_br", stat_branches_o, 32'd0);
        chk("t6.stat_mp", stat_mispred_o, 32'd0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
